// File: rtl/fadd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fadd_pipe
// Purpose  : 3-stage pipelined floating-point add/subtract with RNE rounding,
//            special-value handling, exception flags and valid/ready flow.
// Revision : 1.0
// ============================================================================
module fadd_pipe #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_W+FRAC_W:0] a,
    input  logic [EXP_W+FRAC_W:0] b,
    input  logic                  op_sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+FRAC_W:0] result,
    output logic [3:0]            flags
);
    localparam int                c_w        = 1 + EXP_W + FRAC_W;
    localparam int                c_sig_w    = FRAC_W + 4;
    localparam int                c_expx_w   = EXP_W + 2;
    localparam logic [EXP_W-1:0]  c_exp_ones = '1;
    localparam logic [c_w-1:0]    c_qnan     = {1'b0, c_exp_ones, 1'b1, {(FRAC_W-1){1'b0}}};

    logic w_adv;
    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    // ---------------- Stage 1: decode, specials, swap and align -------------
    logic               w_sa, w_sb;
    logic [EXP_W-1:0]   w_ea, w_eb;
    logic [FRAC_W-1:0]  w_fa, w_fb;
    logic               w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;

    assign w_sa     = a[c_w-1];
    assign w_sb     = b[c_w-1] ^ op_sub;
    assign w_ea     = a[c_w-2:FRAC_W];
    assign w_eb     = b[c_w-2:FRAC_W];
    assign w_fa     = a[FRAC_W-1:0];
    assign w_fb     = b[FRAC_W-1:0];
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (w_ea == c_exp_ones) && (w_fa == '0);
    assign w_b_inf  = (w_eb == c_exp_ones) && (w_fb == '0);
    assign w_a_nan  = (w_ea == c_exp_ones) && (w_fa != '0);
    assign w_b_nan  = (w_eb == c_exp_ones) && (w_fb != '0);

    logic           w_spec;
    logic           w_spec_inv;
    logic [c_w-1:0] w_spec_res;

    always_comb begin
        w_spec     = 1'b1;
        w_spec_inv = 1'b0;
        w_spec_res = '0;
        if (w_a_nan || w_b_nan) begin
            w_spec_res = c_qnan;
        end else if (w_a_inf && w_b_inf && (w_sa != w_sb)) begin
            w_spec_res = c_qnan;
            w_spec_inv = 1'b1;
        end else if (w_a_inf) begin
            w_spec_res = {w_sa, c_exp_ones, {FRAC_W{1'b0}}};
        end else if (w_b_inf) begin
            w_spec_res = {w_sb, c_exp_ones, {FRAC_W{1'b0}}};
        end else if (w_a_zero && w_b_zero) begin
            w_spec_res = {w_sa & w_sb, {(c_w-1){1'b0}}};
        end else if (w_b_zero) begin
            w_spec_res = a;
        end else if (w_a_zero) begin
            w_spec_res = {w_sb, w_eb, w_fb};
        end else begin
            w_spec = 1'b0;
        end
    end

    logic               w_a_ge, w_big_sign, w_small_sticky;
    logic [EXP_W-1:0]   w_big_exp, w_diff;
    logic [c_sig_w-1:0] w_big_sig, w_small_ext, w_small_mask, w_small_sig;

    assign w_a_ge         = {w_ea, w_fa} >= {w_eb, w_fb};
    assign w_big_sign     = w_a_ge ? w_sa : w_sb;
    assign w_big_exp      = w_a_ge ? w_ea : w_eb;
    assign w_diff         = w_a_ge ? (w_ea - w_eb) : (w_eb - w_ea);
    assign w_big_sig      = {1'b1, (w_a_ge ? w_fa : w_fb), 3'b000};
    assign w_small_ext    = {1'b1, (w_a_ge ? w_fb : w_fa), 3'b000};
    // Bits pushed out below the sticky position collapse into the sticky bit.
    assign w_small_mask   = ~({c_sig_w{1'b1}} << w_diff);
    assign w_small_sticky = |(w_small_ext & w_small_mask);
    assign w_small_sig    = (w_small_ext >> w_diff) | {{(c_sig_w-1){1'b0}}, w_small_sticky};

    logic               r1_valid, r1_spec, r1_spec_inv, r1_sign, r1_sub;
    logic [c_w-1:0]     r1_spec_res;
    logic [EXP_W-1:0]   r1_exp;
    logic [c_sig_w-1:0] r1_big, r1_small;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid    <= 1'b0;
            r1_spec     <= 1'b0;
            r1_spec_inv <= 1'b0;
            r1_spec_res <= '0;
            r1_sign     <= 1'b0;
            r1_sub      <= 1'b0;
            r1_exp      <= '0;
            r1_big      <= '0;
            r1_small    <= '0;
        end else if (w_adv) begin
            r1_valid    <= in_valid;
            r1_spec     <= w_spec;
            r1_spec_inv <= w_spec_inv;
            r1_spec_res <= w_spec_res;
            r1_sign     <= w_big_sign;
            r1_sub      <= w_sa ^ w_sb;
            r1_exp      <= w_big_exp;
            r1_big      <= w_big_sig;
            r1_small    <= w_small_sig;
        end
    end

    // ---------------- Stage 2: significand add / subtract -------------------
    logic [c_sig_w:0] w_sum;
    assign w_sum = r1_sub ? ({1'b0, r1_big} - {1'b0, r1_small})
                          : ({1'b0, r1_big} + {1'b0, r1_small});

    logic               r2_valid, r2_spec, r2_spec_inv, r2_sign;
    logic [c_w-1:0]     r2_spec_res;
    logic [EXP_W-1:0]   r2_exp;
    logic [c_sig_w:0]   r2_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid    <= 1'b0;
            r2_spec     <= 1'b0;
            r2_spec_inv <= 1'b0;
            r2_spec_res <= '0;
            r2_sign     <= 1'b0;
            r2_exp      <= '0;
            r2_sum      <= '0;
        end else if (w_adv) begin
            r2_valid    <= r1_valid;
            r2_spec     <= r1_spec;
            r2_spec_inv <= r1_spec_inv;
            r2_spec_res <= r1_spec_res;
            r2_sign     <= r1_sign;
            r2_exp      <= r1_exp;
            r2_sum      <= w_sum;
        end
    end

    // ---------------- Stage 3: normalise, round, pack ----------------------
    logic [c_expx_w-1:0] w_lzc;
    logic                w_lz_done;

    always_comb begin
        w_lzc     = '0;
        w_lz_done = 1'b0;
        for (int i = c_sig_w - 1; i >= 0; i--) begin
            if (!w_lz_done) begin
                if (r2_sum[i]) w_lz_done = 1'b1;
                else           w_lzc     = w_lzc + c_expx_w'(1);
            end
        end
    end

    logic [c_sig_w-1:0]  w_norm;
    logic [c_expx_w-1:0] w_exp_n, w_exp_r;

    always_comb begin
        if (r2_sum[c_sig_w]) begin
            w_norm  = {r2_sum[c_sig_w:2], |r2_sum[1:0]};
            w_exp_n = {2'b00, r2_exp} + c_expx_w'(1);
        end else begin
            w_norm  = r2_sum[c_sig_w-1:0] << w_lzc;
            w_exp_n = {2'b00, r2_exp} - w_lzc;
        end
    end

    logic [FRAC_W:0]   w_mant;
    logic [FRAC_W+1:0] w_mant_r;
    logic [FRAC_W-1:0] w_frac_out;
    logic              w_inexact, w_rnd_up, w_uflow, w_oflow;

    assign w_mant     = w_norm[c_sig_w-1:3];
    assign w_inexact  = |w_norm[2:0];
    assign w_rnd_up   = w_norm[2] & (w_norm[1] | w_norm[0] | w_mant[0]);
    assign w_mant_r   = {1'b0, w_mant} + {{(FRAC_W+1){1'b0}}, w_rnd_up};
    assign w_frac_out = w_mant_r[FRAC_W+1] ? w_mant_r[FRAC_W:1] : w_mant_r[FRAC_W-1:0];
    assign w_exp_r    = w_exp_n + {{(c_expx_w-1){1'b0}}, w_mant_r[FRAC_W+1]};
    // Exponents are two bits wider than the field, so the MSB is a sign bit.
    assign w_uflow    = w_exp_n[c_expx_w-1] | (w_exp_n == '0);
    assign w_oflow    = ~w_exp_r[c_expx_w-1] & (w_exp_r[c_expx_w-2:0] >= {1'b0, c_exp_ones});

    logic [c_w-1:0] w_res;
    logic [3:0]     w_flags;

    always_comb begin
        w_res   = '0;
        w_flags = '0;
        if (r2_spec) begin
            w_res   = r2_spec_res;
            w_flags = {r2_spec_inv, 3'b000};
        end else if (r2_sum == '0) begin
            w_res   = '0;
        end else if (w_uflow) begin
            w_res   = {r2_sign, {(c_w-1){1'b0}}};
            w_flags = 4'b0011;
        end else if (w_oflow) begin
            w_res   = {r2_sign, c_exp_ones, {FRAC_W{1'b0}}};
            w_flags = 4'b0101;
        end else begin
            w_res   = {r2_sign, w_exp_r[EXP_W-1:0], w_frac_out};
            w_flags = {3'b000, w_inexact};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (w_adv) begin
            out_valid <= r2_valid;
            result    <= w_res;
            flags     <= w_flags;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fadd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fadd_pipe
// Purpose  : Scoreboard bench for fadd_pipe against an exact-integer model.
// Revision : 1.0
// ============================================================================
module tb_fadd_pipe;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int W      = 1 + EXP_W + FRAC_W;
    localparam int EMAX   = (1 << EXP_W) - 1;
    localparam int BIG_W  = 320;
    localparam logic [W-1:0] QNAN = 32'h7FC0_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         op_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic [3:0]   flags;

    int checks   = 0;
    int failures = 0;
    logic [W+3:0] exp_q[$];

    fadd_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Exact sum on wide integers, then a single round-to-nearest-even.
    function automatic logic [W+3:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic sub);
        logic sx, sy, s, inexact;
        int ex, ey, p, e, sh;
        logic [BIG_W-1:0] vx, vy, mag, rem, half, mant;
        sx = x[W-1];
        sy = y[W-1] ^ sub;
        ex = int'(x[W-2:FRAC_W]);
        ey = int'(y[W-2:FRAC_W]);
        if ((ex == EMAX && x[FRAC_W-1:0] != 0) || (ey == EMAX && y[FRAC_W-1:0] != 0))
            return {4'b0000, QNAN};
        if (ex == EMAX && ey == EMAX && sx != sy) return {4'b1000, QNAN};
        if (ex == EMAX) return {4'b0000, sx, 8'hFF, 23'd0};
        if (ey == EMAX) return {4'b0000, sy, 8'hFF, 23'd0};
        if (ex == 0 && ey == 0) return {4'b0000, sx & sy, 31'd0};
        if (ey == 0) return {4'b0000, x};
        if (ex == 0) return {4'b0000, sy, y[W-2:0]};
        vx = BIG_W'({1'b1, x[FRAC_W-1:0]}) << (ex - 1);
        vy = BIG_W'({1'b1, y[FRAC_W-1:0]}) << (ey - 1);
        if (sx == sy)      begin mag = vx + vy; s = sx; end
        else if (vx >= vy) begin mag = vx - vy; s = sx; end
        else               begin mag = vy - vx; s = sy; end
        if (mag == 0) return '0;
        p = 0;
        for (int i = 0; i < BIG_W; i++) if (mag[i]) p = i;
        e = p + 1 - FRAC_W;
        if (e <= 0) return {4'b0011, s, 31'd0};
        sh      = p - FRAC_W;
        mant    = mag >> sh;
        rem     = mag & ((BIG_W'(1) << sh) - BIG_W'(1));
        half    = (sh > 0) ? (BIG_W'(1) << (sh - 1)) : '0;
        inexact = (rem != 0);
        if (sh > 0 && (rem > half || (rem == half && mant[0]))) mant = mant + BIG_W'(1);
        if (mant[FRAC_W+1]) begin mant = mant >> 1; e++; end
        if (e >= EMAX) return {4'b0101, s, 8'hFF, 23'd0};
        return {3'b000, inexact, s, e[EXP_W-1:0], mant[FRAC_W-1:0]};
    endfunction

    function automatic logic [W-1:0] rand_op(input logic [W-1:0] near);
        logic [W-1:0] v;
        int k;
        v = $urandom;
        k = $urandom_range(0, 15);
        if (k == 0) begin
            v[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            if ($urandom_range(0, 1) == 0) v[22:0] = '0;
        end else if (k <= 3) begin
            v[31]   = 1'($urandom_range(0, 1));
            v[30:0] = near[30:0] ^ (31'($urandom) & 31'h0000_000F);
        end else if (k == 4) v[30:23] = 8'($urandom_range(1, 254));
        else if (k == 5)     v[30:23] = 8'($urandom_range(240, 254));
        else if (k == 6)     v[30:23] = 8'($urandom_range(1, 20));
        else                 v[30:23] = 8'($urandom_range(110, 145));
        return v;
    endfunction

    // Called at posedge+1; returns at the next posedge+1.
    task automatic drive_cycle(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic sub, input logic [W+3:0] expv, output logic acc);
        in_valid = v;
        a        = x;
        b        = y;
        op_sub   = sub;
        @(negedge clk);
        acc = v && in_ready;
        if (acc) exp_q.push_back(expv);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub,
                         input logic [W+3:0] expv);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            drive_cycle(1'b1, x, y, sub, expv, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: got in_ready=%0b expected 1", in_ready);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        logic [W+3:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got %0h expected none", result);
                end else begin
                    e = exp_q.pop_front();
                    check("result", result, e[W-1:0]);
                    check("flags", flags, e[W+3:W]);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int           lat, cnt;
        logic         acc;
        logic [W-1:0] x, y, prev, hold_r;
        logic [3:0]   hold_f;
        logic         s;

        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_flags", flags, 0);
        check("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        issue(32'h3F80_0000, 32'h3F80_0000, 1'b0, {4'h0, 32'h4000_0000});
        lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
        end
        check("latency", lat, 3);
        @(posedge clk);
        #1;

        issue(32'h3F80_0000, 32'h3F80_0000, 1'b1, {4'h0, 32'h0000_0000});
        issue(32'h8000_0000, 32'h8000_0000, 1'b0, {4'h0, 32'h8000_0000});
        issue(32'h3F80_0000, 32'h3380_0000, 1'b0, {4'h1, 32'h3F80_0000});
        issue(32'h3F80_0001, 32'h3380_0000, 1'b0, {4'h1, 32'h3F80_0002});
        issue(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, {4'h5, 32'h7F80_0000});
        issue(32'h7F80_0000, 32'hFF80_0000, 1'b0, {4'h8, 32'h7FC0_0000});
        issue(32'h7FC0_0001, 32'h3F80_0000, 1'b0, {4'h0, 32'h7FC0_0000});
        issue(32'hFF80_0000, 32'h3F80_0000, 1'b0, {4'h0, 32'hFF80_0000});
        issue(32'h4049_0FDB, 32'h8000_0000, 1'b0, {4'h0, 32'h4049_0FDB});
        issue(32'h0080_0001, 32'h0080_0000, 1'b1, {4'h3, 32'h0000_0000});
        issue(32'h0000_0000, 32'h8000_0000, 1'b0, {4'h0, 32'h0000_0000});
        drain();

        // Backpressure: three operations fill the pipe, the rest are refused.
        out_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            x = rand_op(32'h3F80_0000);
            y = rand_op(x);
            drive_cycle(1'b1, x, y, 1'b0, ref_model(x, y, 1'b0), acc);
            if (acc) cnt++;
        end
        check("bp_accepted", cnt, 3);
        check("bp_in_ready", in_ready, 0);
        hold_r = result;
        hold_f = flags;
        repeat (2) begin
            @(negedge clk);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_result", result, hold_r);
            check("bp_hold_flags", flags, hold_f);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_release_valid", out_valid, 1);
        end
        @(negedge clk);
        check("bp_no_duplicate", out_valid, 0);
        @(posedge clk);
        #1;
        drain();

        prev = 32'h3F80_0000;
        for (int i = 0; i < 400; i++) begin
            x = rand_op(prev);
            y = rand_op(x);
            s = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            drive_cycle(($urandom_range(0, 3) != 0), x, y, s, ref_model(x, y, s), acc);
            prev = y;
        end
        out_ready = 1'b1;
        drain();

        // Reset with two operations in flight.
        issue(32'h3F80_0000, 32'h4000_0000, 1'b0, ref_model(32'h3F80_0000, 32'h4000_0000, 1'b0));
        issue(32'h4040_0000, 32'h3F80_0000, 1'b1, ref_model(32'h4040_0000, 32'h3F80_0000, 1'b1));
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("post_reset_results", cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
